// File: rtl/ddr_rw_arbiter.sv
// Arbitrates the DDR AXI4 master port between write-FIFO drain and read-FIFO fill bursts.
// Round-robin grants of fixed-length bursts; per-direction frame address counters with restart.
module ddr_rw_arbiter #(
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned ADDR_W       = 28,
  parameter int unsigned WR_BASE      = 0,
  parameter int unsigned RD_BASE      = 0,
  parameter int unsigned FRAME_BURSTS = 7200,
  parameter int unsigned RD_THRESH    = 192
) (
  input  logic              ddr_clk,
  input  logic              rst,
  input  logic              ddr_init_done,
  input  logic              vs_in_pulse,
  input  logic              vs_out_pulse,
  input  logic [8:0]        wfifo_rd_water_level,
  output logic              wfifo_rd_req,
  input  logic [8:0]        rfifo_wr_water_level,
  output logic              rfifo_wr_req,
  output logic [ADDR_W-1:0] axi_awaddr,
  output logic [7:0]        axi_awlen,
  output logic              axi_awvalid,
  input  logic              axi_awready,
  output logic              axi_wvalid,
  output logic              axi_wlast,
  input  logic              axi_wready,
  input  logic              axi_bvalid,
  output logic              axi_bready,
  output logic [ADDR_W-1:0] axi_araddr,
  output logic [7:0]        axi_arlen,
  output logic              axi_arvalid,
  input  logic              axi_arready,
  input  logic              axi_rvalid,
  input  logic              axi_rlast,
  output logic              axi_rready,
  output logic              busy
);

  localparam int unsigned CntW  = $clog2(FRAME_BURSTS) + 1;
  localparam int unsigned BeatW = $clog2(BURST_LEN) + 1;

  localparam logic [ADDR_W-1:0] WrBase     = ADDR_W'(WR_BASE);
  localparam logic [ADDR_W-1:0] RdBase     = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W-1:0] BurstBytes = ADDR_W'(BURST_LEN * 32);
  localparam logic [CntW-1:0]   CntLast    = CntW'(FRAME_BURSTS - 1);
  localparam logic [BeatW-1:0]  BeatLast   = BeatW'(BURST_LEN - 1);
  localparam logic [8:0]        LvlBurst   = 9'(BURST_LEN);
  localparam logic [8:0]        LvlRdThr   = 9'(RD_THRESH);

  typedef enum logic [2:0] {
    StIdle, StWrAddr, StWrData, StWrResp, StRdAddr, StRdData
  } state_e;

  state_e             state_q;
  logic               last_wr_q;
  logic [ADDR_W-1:0]  wr_addr_q, rd_addr_q;
  logic [CntW-1:0]    wr_cnt_q, rd_cnt_q;
  logic [BeatW-1:0]   beat_q;
  logic               wr_restart_q, rd_restart_q;
  logic               wr_restart_d, rd_restart_d;
  logic               awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q, busy_q;

  logic               wr_elig, rd_elig, grant_wr, grant_rd;
  logic [ADDR_W-1:0]  wr_addr_nxt, rd_addr_nxt;
  logic [CntW-1:0]    wr_cnt_nxt, rd_cnt_nxt;

  always_comb begin
    wr_elig  = ddr_init_done & (wfifo_rd_water_level >= LvlBurst);
    rd_elig  = ddr_init_done & (rfifo_wr_water_level < LvlRdThr);
    // Both eligible: the direction not granted last time wins.
    grant_wr = wr_elig & (~rd_elig | ~last_wr_q);
    grant_rd = rd_elig & ~grant_wr;
  end

  // A pulse on the clearing cycle re-arms the flag, so no frame start is lost.
  always_comb begin
    wr_restart_d = (wr_restart_q & (state_q != StIdle)) | vs_in_pulse;
    rd_restart_d = (rd_restart_q & (state_q != StIdle)) | vs_out_pulse;
  end

  always_comb begin
    wr_addr_nxt = wr_addr_q + BurstBytes;
    wr_cnt_nxt  = wr_cnt_q + CntW'(1);
    if (wr_cnt_q == CntLast) begin
      wr_addr_nxt = WrBase;
      wr_cnt_nxt  = '0;
    end
    rd_addr_nxt = rd_addr_q + BurstBytes;
    rd_cnt_nxt  = rd_cnt_q + CntW'(1);
    if (rd_cnt_q == CntLast) begin
      rd_addr_nxt = RdBase;
      rd_cnt_nxt  = '0;
    end
  end

  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_wr_q    <= 1'b0;
      wr_addr_q    <= WrBase;
      rd_addr_q    <= RdBase;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      beat_q       <= '0;
      wr_restart_q <= 1'b0;
      rd_restart_q <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wr_restart_q <= wr_restart_d;
      rd_restart_q <= rd_restart_d;
      unique case (state_q)
        StIdle: begin
          if (wr_restart_q) begin
            wr_addr_q <= WrBase;
            wr_cnt_q  <= '0;
          end
          if (rd_restart_q) begin
            rd_addr_q <= RdBase;
            rd_cnt_q  <= '0;
          end
          if (grant_wr) begin
            state_q   <= StWrAddr;
            awvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            last_wr_q <= 1'b1;
          end else if (grant_rd) begin
            state_q   <= StRdAddr;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            last_wr_q <= 1'b0;
          end
        end
        StWrAddr: begin
          if (axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= StWrData;
          end
        end
        StWrData: begin
          if (axi_wready) begin
            if (beat_q == BeatLast) begin
              beat_q   <= '0;
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= StWrResp;
            end else begin
              beat_q <= beat_q + BeatW'(1);
            end
          end
        end
        StWrResp: begin
          if (axi_bvalid) begin
            bready_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_addr_q <= wr_addr_nxt;
            wr_cnt_q  <= wr_cnt_nxt;
            state_q   <= StIdle;
          end
        end
        StRdAddr: begin
          if (axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdData;
          end
        end
        StRdData: begin
          if (axi_rvalid && axi_rlast) begin
            rready_q  <= 1'b0;
            busy_q    <= 1'b0;
            rd_addr_q <= rd_addr_nxt;
            rd_cnt_q  <= rd_cnt_nxt;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign axi_awaddr   = wr_addr_q;
  assign axi_araddr   = rd_addr_q;
  assign axi_awlen    = 8'(BURST_LEN - 1);
  assign axi_arlen    = 8'(BURST_LEN - 1);
  assign axi_awvalid  = awvalid_q;
  assign axi_wvalid   = wvalid_q;
  assign axi_wlast    = wvalid_q & (beat_q == BeatLast);
  assign axi_bready   = bready_q;
  assign axi_arvalid  = arvalid_q;
  assign axi_rready   = rready_q;
  assign busy         = busy_q;
  assign wfifo_rd_req = wvalid_q & axi_wready;
  assign rfifo_wr_req = rready_q & axi_rvalid;

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// Bench for ddr_rw_arbiter: burst-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_ddr_rw_arbiter;
  localparam int BL  = 16;
  localparam int FB  = 4;
  localparam int RDT = 192;
  localparam int AW  = 28;
  localparam int WRB = 0;
  localparam int RDB = 0;

  localparam int MIdle = 0, MWa = 1, MWd = 2, MWr = 3, MRa = 4, MRd = 5;

  logic          ddr_clk = 1'b0;
  logic          rst = 1'b1;
  logic          ddr_init_done = 1'b0;
  logic          vs_in_pulse = 1'b0, vs_out_pulse = 1'b0;
  logic [8:0]    wfifo_rd_water_level = '0, rfifo_wr_water_level = '0;
  logic          wfifo_rd_req, rfifo_wr_req;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [7:0]    axi_awlen, axi_arlen;
  logic          axi_awvalid, axi_wvalid, axi_wlast, axi_bready;
  logic          axi_arvalid, axi_rready, busy;
  logic          axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
  logic          axi_arready = 1'b0, axi_rvalid = 1'b0, axi_rlast = 1'b0;

  ddr_rw_arbiter #(
    .BURST_LEN(BL), .ADDR_W(AW), .WR_BASE(WRB), .RD_BASE(RDB),
    .FRAME_BURSTS(FB), .RD_THRESH(RDT)
  ) dut (
    .ddr_clk(ddr_clk), .rst(rst), .ddr_init_done(ddr_init_done),
    .vs_in_pulse(vs_in_pulse), .vs_out_pulse(vs_out_pulse),
    .wfifo_rd_water_level(wfifo_rd_water_level), .wfifo_rd_req(wfifo_rd_req),
    .rfifo_wr_water_level(rfifo_wr_water_level), .rfifo_wr_req(rfifo_wr_req),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_wvalid(axi_wvalid), .axi_wlast(axi_wlast),
    .axi_wready(axi_wready), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast),
    .axi_rready(axi_rready), .busy(busy)
  );

  always #5 ddr_clk = ~ddr_clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: burst phase, beats seen, burst index within the frame.
  int m_mode, m_wbeats, m_rbeats, m_widx, m_ridx;
  bit m_wpend, m_rpend, m_last_wr;

  function automatic void model_reset();
    m_mode = MIdle; m_wbeats = 0; m_rbeats = 0; m_widx = 0; m_ridx = 0;
    m_wpend = 0; m_rpend = 0; m_last_wr = 0;
  endfunction

  function automatic void model_step();
    bit we, re;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_mode == MIdle) begin
      if (m_wpend) m_widx = 0;
      if (m_rpend) m_ridx = 0;
      m_wpend = vs_in_pulse;
      m_rpend = vs_out_pulse;
      we = ddr_init_done && (int'(wfifo_rd_water_level) >= BL);
      re = ddr_init_done && (int'(rfifo_wr_water_level) < RDT);
      if (we && (!re || !m_last_wr)) begin
        m_mode = MWa; m_last_wr = 1;
      end else if (re) begin
        m_mode = MRa; m_last_wr = 0;
      end
    end else begin
      m_wpend |= vs_in_pulse;
      m_rpend |= vs_out_pulse;
      case (m_mode)
        MWa: if (axi_awready) begin m_mode = MWd; m_wbeats = 0; end
        MWd: if (axi_wready) begin
          m_wbeats++;
          if (m_wbeats == BL) m_mode = MWr;
        end
        MWr: if (axi_bvalid) begin m_mode = MIdle; m_widx = (m_widx + 1) % FB; end
        MRa: if (axi_arready) begin m_mode = MRd; m_rbeats = 0; end
        MRd: if (axi_rvalid) begin
          m_rbeats++;
          if (axi_rlast) begin m_mode = MIdle; m_ridx = (m_ridx + 1) % FB; end
        end
        default: ;
      endcase
    end
  endfunction

  task automatic compare();
    chk("busy", busy, m_mode != MIdle);
    chk("awvalid", axi_awvalid, m_mode == MWa);
    chk("wvalid", axi_wvalid, m_mode == MWd);
    chk("wlast", axi_wlast, (m_mode == MWd) && (m_wbeats == BL - 1));
    chk("bready", axi_bready, m_mode == MWr);
    chk("arvalid", axi_arvalid, m_mode == MRa);
    chk("rready", axi_rready, m_mode == MRd);
    chk("wfifo_rd_req", wfifo_rd_req, (m_mode == MWd) && axi_wready);
    chk("rfifo_wr_req", rfifo_wr_req, (m_mode == MRd) && axi_rvalid);
    chk("awlen", axi_awlen, BL - 1);
    chk("arlen", axi_arlen, BL - 1);
    if (m_mode == MWa) chk("awaddr", axi_awaddr, WRB + m_widx * BL * 32);
    if (m_mode == MRa) chk("araddr", axi_araddr, RDB + m_ridx * BL * 32);
  endtask

  // Observations for the directed literal checks.
  int unsigned aw_q[$], ar_q[$];
  bit          grant_q[$];
  int          pops, wlast_acc, bad_pop, valid_seen;

  function automatic void clear_obs();
    aw_q.delete(); ar_q.delete(); grant_q.delete();
    pops = 0; wlast_acc = 0; bad_pop = 0; valid_seen = 0;
  endfunction

  always @(posedge ddr_clk) begin
    model_step();
    #3;
    if (rst) model_reset();
    compare();
    if (axi_awvalid && axi_awready) begin aw_q.push_back(axi_awaddr); grant_q.push_back(1'b1); end
    if (axi_arvalid && axi_arready) begin ar_q.push_back(axi_araddr); grant_q.push_back(1'b0); end
    if (wfifo_rd_req) pops++;
    if (axi_wlast && axi_wready) wlast_acc++;
    if (wfifo_rd_req && !axi_wready) bad_pop++;
    if (axi_awvalid || axi_arvalid || axi_wvalid || axi_rready || busy) valid_seen++;
  end

  // Stimulus knobs: -1 level means random each cycle; probabilities in percent.
  int k_wlvl, k_rlvl, k_paw, k_pw, k_pb, k_par, k_pr, k_pvs, k_prst;
  bit k_init, k_init_rand, k_wtoggle;

  function automatic bit pct(int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic drive();
    ddr_init_done = k_init_rand ? pct(90) : k_init;
    wfifo_rd_water_level = (k_wlvl < 0) ? 9'($urandom_range(511)) : 9'(k_wlvl);
    rfifo_wr_water_level = (k_rlvl < 0) ? 9'($urandom_range(511)) : 9'(k_rlvl);
    axi_awready = pct(k_paw);
    axi_wready  = k_wtoggle ? ~axi_wready : pct(k_pw);
    axi_bvalid  = pct(k_pb);
    axi_arready = pct(k_par);
    axi_rvalid  = pct(k_pr);
    axi_rlast   = (m_mode == MRd) && (m_rbeats == BL - 1);
    vs_in_pulse  = (k_pvs > 0) && pct(k_pvs);
    vs_out_pulse = (k_pvs > 0) && pct(k_pvs);
    rst = (k_prst > 0) && (int'($urandom_range(999)) < k_prst);
  endtask

  task automatic tick();
    @(posedge ddr_clk);
    #2;
    drive();
  endtask

  task automatic set_knobs(int wl, int rl, bit init);
    k_wlvl = wl; k_rlvl = rl; k_init = init; k_init_rand = 0; k_wtoggle = 0;
    k_paw = 100; k_pw = 100; k_pb = 100; k_par = 100; k_pr = 100; k_pvs = 0; k_prst = 0;
  endtask

  task automatic do_reset();
    @(posedge ddr_clk);
    #2;
    rst = 1'b1;
    vs_in_pulse = 1'b0;
    vs_out_pulse = 1'b0;
    repeat (2) @(posedge ddr_clk);
    #2;
    clear_obs();
    drive();
  endtask

  task automatic wait_aw(int n, int budget, string name);
    for (int i = 0; i < budget && aw_q.size() < n; i++) tick();
    chk(name, aw_q.size() >= n, 1);
  endtask

  int unsigned exp_aw[5] = '{'h0, 'h200, 'h400, 'h600, 'h0};
  bit          exp_g[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    set_knobs(0, 511, 0);
    model_reset();
    clear_obs();
    repeat (2) @(posedge ddr_clk);
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
    chk("reset_reqs", {wfifo_rd_req, rfifo_wr_req}, 0);

    // Single write burst, read side full.
    set_knobs(16, 255, 1);
    do_reset();
    wait_aw(2, 200, "s1_two_bursts");
    if (aw_q.size() >= 2) begin
      chk("s1_awaddr0", aw_q[0], 'h0);
      chk("s1_awaddr1", aw_q[1], 'h200);
    end
    chk("s1_pops", pops, 16);
    chk("s1_wlast", wlast_acc, 1);
    chk("s1_no_reads", ar_q.size(), 0);

    // Both eligible: grants alternate starting with write.
    set_knobs(20, 0, 1);
    do_reset();
    for (int i = 0; i < 400 && grant_q.size() < 4; i++) tick();
    chk("s2_grants", grant_q.size() >= 4, 1);
    if (grant_q.size() >= 4)
      for (int i = 0; i < 4; i++) chk("s2_grant_order", grant_q[i], exp_g[i]);
    chk("s2_ar_count", ar_q.size() >= 2, 1);
    if (ar_q.size() >= 2) begin
      chk("s2_araddr0", ar_q[0], 'h0);
      chk("s2_araddr1", ar_q[1], 'h200);
    end

    // wready toggling every cycle.
    set_knobs(16, 255, 1);
    k_wtoggle = 1;
    do_reset();
    wait_aw(2, 300, "s3_two_bursts");
    chk("s3_pops", pops, 16);
    chk("s3_wlast", wlast_acc, 1);
    chk("s3_bad_pop", bad_pop, 0);

    // Frame wrap after FB bursts.
    set_knobs(16, 255, 1);
    do_reset();
    wait_aw(5, 500, "s4_five_bursts");
    if (aw_q.size() >= 5)
      for (int i = 0; i < 5; i++) chk("s4_awaddr_seq", aw_q[i], exp_aw[i]);

    // Frame start during the burst at 0x400.
    do_reset();
    for (int i = 0; i < 300 && !(aw_q.size() >= 3 && axi_wvalid); i++) tick();
    chk("s5_in_burst3", aw_q.size() == 3 && axi_wvalid, 1);
    vs_in_pulse = 1'b1;
    wait_aw(4, 200, "s5_four_bursts");
    if (aw_q.size() >= 4) begin
      chk("s5_awaddr2", aw_q[2], 'h400);
      chk("s5_awaddr3", aw_q[3], WRB);
    end
    chk("s5_pops", pops, 48);

    // Not calibrated: nothing may start.
    set_knobs(16, 0, 0);
    do_reset();
    repeat (100) tick();
    chk("s6_no_activity", valid_seen, 0);

    // Reset in the middle of write data.
    set_knobs(16, 255, 1);
    for (int i = 0; i < 300 && !(aw_q.size() >= 3 && axi_wvalid); i++) tick();
    chk("s7_in_burst3", aw_q.size() == 3 && axi_wvalid, 1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("s7_rst_valids", {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, axi_arvalid,
                          axi_rready, busy}, 0);
    chk("s7_rst_req", wfifo_rd_req, 0);
    chk("s7_rst_addr", axi_awaddr, WRB);
    clear_obs();
    wait_aw(1, 100, "s7_restart");
    if (aw_q.size() >= 1) chk("s7_awaddr", aw_q[0], WRB);

    // Randomized traffic with frame pulses and occasional resets.
    for (int seg = 0; seg < 5; seg++) begin
      set_knobs(-1, -1, 1);
      k_init_rand = 1;
      k_paw = 20 + int'($urandom_range(80));
      k_pw  = 20 + int'($urandom_range(80));
      k_pb  = 20 + int'($urandom_range(80));
      k_par = 20 + int'($urandom_range(80));
      k_pr  = 20 + int'($urandom_range(80));
      k_pvs = 3;
      k_prst = 2;
      repeat (2000) tick();
    end

    set_knobs(0, 511, 0);
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
